// File: rtl/fp_spi_frame_ctrl_pkg.sv
// Shared definitions for the front panel SPI frame controller.
package fp_spi_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCmd     = 3'd1,
        StRdFetch = 3'd2,
        StData    = 3'd3,
        StDone    = 3'd4
    } state_e;

    localparam int unsigned CMD_RW_BIT     = 7;
    localparam int unsigned DEFAULT_ADDR_W = 4;

endpackage

// File: rtl/fp_spi_frame_ctrl_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin with rise/fall pulse detection.
module fp_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/fp_spi_frame_ctrl.sv
// SPI mode-0 slave that turns 2-byte command frames into register-bus write/read cycles.
module fp_spi_frame_ctrl
    import fp_spi_frame_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS,
    output logic              MISO,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [7:0]        REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RE,
    input  logic [7:0]        REG_RDATA,
    output logic              BUSY,
    output logic              FRAME_ERR
);

    logic sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl_unused, mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    fp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i   (CLK),
        .rst_i   (RST),
        .d_i     (SCLK),
        .level_o (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    fp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_i   (CLK),
        .rst_i   (RST),
        .d_i     (SS),
        .level_o (ss_lvl),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    fp_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i   (CLK),
        .rst_i   (RST),
        .d_i     (MOSI),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        rx_sr_q, rx_sr_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic              miso_q, miso_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;
    logic              fetch_ph_q, fetch_ph_d;
    logic              byte_done_q, byte_done_d;
    logic              sample;

    // DONE and IDLE never shift; IDLE clears the shifter on the next ss_fall anyway.
    assign sample = sclk_rise & ~ss_lvl &
                    ((state_q == StCmd) | (state_q == StRdFetch) | (state_q == StData));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            rx_sr_q     <= 8'd0;
            tx_sr_q     <= 8'd0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 8'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            fetch_ph_q  <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            fetch_ph_q  <= fetch_ph_d;
            byte_done_q <= byte_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        err_d       = 1'b0;
        rd_d        = rd_q;
        fetch_ph_d  = fetch_ph_q;
        byte_done_d = 1'b0;

        if (sample) begin
            rx_sr_d     = {rx_sr_q[6:0], mosi_lvl};
            cnt_d       = cnt_q + 3'd1;
            byte_done_d = (cnt_q == 3'd7);
        end

        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d = StCmd;
                    cnt_d   = 3'd0;
                    rx_sr_d = 8'd0;
                end
            end
            StCmd: begin
                if (ss_rise) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                end else if (byte_done_q) begin
                    addr_d = rx_sr_q[ADDR_W-1:0];
                    rd_d   = rx_sr_q[CMD_RW_BIT];
                    if (rx_sr_q[CMD_RW_BIT]) begin
                        state_d    = StRdFetch;
                        re_d       = 1'b1;
                        fetch_ph_d = 1'b0;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StRdFetch: begin
                if (ss_rise) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                end else if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    tx_sr_d = REG_RDATA;
                    miso_d  = REG_RDATA[7];
                    state_d = StData;
                end
            end
            StData: begin
                if (ss_rise) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                end else if (byte_done_q) begin
                    if (!rd_q) begin
                        wdata_d = rx_sr_q;
                        we_d    = 1'b1;
                    end
                    state_d = StDone;
                    miso_d  = 1'b0;
                end else if (rd_q && sclk_fall && (cnt_q != 3'd0)) begin
                    // The fall trailing the cmd byte arrives with cnt==0 and must not shift.
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    miso_d  = tx_sr_q[6];
                end
            end
            StDone: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                miso_d  = 1'b0;
            end
        endcase
    end

    assign MISO      = miso_q;
    assign REG_ADDR  = addr_q;
    assign REG_WDATA = wdata_q;
    assign REG_WE    = we_q;
    assign REG_RE    = re_q;
    assign BUSY      = (state_q != StIdle);
    assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_fp_spi_frame_ctrl.sv
// Directed self-checking bench for fp_spi_frame_ctrl: write, read, abort, overrun, b2b, reset.
module tb_fp_spi_frame_ctrl;

    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF_SCLK   = 80;

    logic              CLK;
    logic              RST;
    logic              SCLK;
    logic              MOSI;
    logic              SS;
    logic              MISO;
    logic [ADDR_W-1:0] REG_ADDR;
    logic [7:0]        REG_WDATA;
    logic              REG_WE;
    logic              REG_RE;
    logic [7:0]        REG_RDATA;
    logic              BUSY;
    logic              FRAME_ERR;

    fp_spi_frame_ctrl #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .SS        (SS),
        .MISO      (MISO),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_WE    (REG_WE),
        .REG_RE    (REG_RE),
        .REG_RDATA (REG_RDATA),
        .BUSY      (BUSY),
        .FRAME_ERR (FRAME_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    int          we_cnt = 0;
    int          re_cnt = 0;
    int          err_cnt = 0;
    logic [3:0]  log_addr [16];
    logic [7:0]  log_data [16];
    logic [7:0]  rd_val = 8'h00;
    logic        re_prev = 1'b0;

    initial REG_RDATA = 8'hFF;

    // Bus monitor plus register-file model: read data valid through the cycle after REG_RE.
    always @(negedge CLK) begin
        if (REG_WE) begin
            if (we_cnt < 16) begin
                log_addr[we_cnt] = REG_ADDR;
                log_data[we_cnt] = REG_WDATA;
            end
            we_cnt++;
        end
        if (REG_RE) re_cnt++;
        if (FRAME_ERR) err_cnt++;
        if (REG_RE) begin
            REG_RDATA = rd_val;
            re_prev   = 1'b1;
        end else if (re_prev) begin
            re_prev = 1'b0;
        end else begin
            REG_RDATA = 8'hFF;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    // Mode 0 master: MOSI set while SCLK low, MISO captured just before each rise.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[7-i];
            #(HALF_SCLK);
            rx = {rx[6:0], MISO};
            SCLK = 1'b1;
            #(HALF_SCLK);
            SCLK = 1'b0;
        end
    endtask

    task automatic ss_low();
        SS = 1'b0;
        #(HALF_SCLK);
    endtask

    task automatic ss_high();
        #(HALF_SCLK);
        SS = 1'b1;
    endtask

    int         we_base;
    int         re_base;
    int         err_base;
    logic [7:0] rx;

    task automatic snap();
        we_base  = we_cnt;
        re_base  = re_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        RST  = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        SS   = 1'b1;
        wait_clk(4);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_addr", {28'd0, REG_ADDR}, 32'd0);
        check("rst_wdata", {24'd0, REG_WDATA}, 32'd0);
        check("rst_we", {31'd0, REG_WE}, 32'd0);
        check("rst_re", {31'd0, REG_RE}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_err", {31'd0, FRAME_ERR}, 32'd0);
        RST = 1'b0;
        wait_clk(6);

        // Write addr 5 <- 0xA3
        snap();
        ss_low();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'hA3, 8, rx);
        check("wr_miso_zero", {24'd0, rx}, 32'h00);
        wait_clk(4);
        check("wr_busy_done", {31'd0, BUSY}, 32'd1);
        ss_high();
        wait_clk(6);
        check("wr_we_cnt", we_cnt - we_base, 32'd1);
        check("wr_addr", {28'd0, log_addr[we_base]}, 32'd5);
        check("wr_data", {24'd0, log_data[we_base]}, 32'hA3);
        check("wr_err_cnt", err_cnt - err_base, 32'd0);
        check("wr_busy_idle", {31'd0, BUSY}, 32'd0);
        check("wr_reg_wdata", {24'd0, REG_WDATA}, 32'hA3);

        // Read addr 0xC, register returns 0x5A
        snap();
        rd_val = 8'h5A;
        ss_low();
        spi_xfer(8'h8C, 8, rx);
        MOSI = 1'b0;
        spi_xfer(8'h00, 8, rx);
        check("rd_miso_bits", {24'd0, rx}, 32'h5A);
        wait_clk(4);
        check("rd_miso_done", {31'd0, MISO}, 32'd0);
        ss_high();
        wait_clk(6);
        check("rd_re_cnt", re_cnt - re_base, 32'd1);
        check("rd_addr", {28'd0, REG_ADDR}, 32'hC);
        check("rd_we_cnt", we_cnt - we_base, 32'd0);
        check("rd_err_cnt", err_cnt - err_base, 32'd0);

        // Abort after 5 data bits of a write to addr 3
        snap();
        ss_low();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'hF0, 5, rx);
        @(negedge CLK);
        SS = 1'b1;
        wait_clk(SYNC_STAGES + 2);
        check("ab_busy", {31'd0, BUSY}, 32'd0);
        check("ab_err_cnt", err_cnt - err_base, 32'd1);
        wait_clk(4);
        check("ab_err_width", err_cnt - err_base, 32'd1);
        check("ab_we_cnt", we_cnt - we_base, 32'd0);
        check("ab_addr", {28'd0, REG_ADDR}, 32'd3);

        // Overrun: 8 extra SCLKs after the data byte
        snap();
        ss_low();
        spi_xfer(8'h06, 8, rx);
        spi_xfer(8'h3C, 8, rx);
        spi_xfer(8'hFF, 8, rx);
        check("ov_miso_zero", {24'd0, rx}, 32'h00);
        ss_high();
        wait_clk(6);
        check("ov_we_cnt", we_cnt - we_base, 32'd1);
        check("ov_data", {24'd0, log_data[we_base]}, 32'h3C);
        check("ov_addr", {28'd0, log_addr[we_base]}, 32'd6);
        check("ov_err_cnt", err_cnt - err_base, 32'd0);

        // Back-to-back: one SCLK period gap, then a one-CLK gap
        snap();
        ss_low();
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h11, 8, rx);
        ss_high();
        #(2 * HALF_SCLK);
        ss_low();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h22, 8, rx);
        #(HALF_SCLK);
        @(negedge CLK);
        SS = 1'b1;
        @(negedge CLK);
        SS = 1'b0;
        #(HALF_SCLK);
        spi_xfer(8'h07, 8, rx);
        spi_xfer(8'h77, 8, rx);
        ss_high();
        wait_clk(6);
        check("bb_we_cnt", we_cnt - we_base, 32'd3);
        check("bb_addr0", {28'd0, log_addr[we_base]}, 32'd1);
        check("bb_data0", {24'd0, log_data[we_base]}, 32'h11);
        check("bb_addr1", {28'd0, log_addr[we_base+1]}, 32'd2);
        check("bb_data1", {24'd0, log_data[we_base+1]}, 32'h22);
        check("bb_addr2", {28'd0, log_addr[we_base+2]}, 32'd7);
        check("bb_data2", {24'd0, log_data[we_base+2]}, 32'h77);
        check("bb_err_cnt", err_cnt - err_base, 32'd0);

        // Reset right after the cmd byte, then a fresh frame
        snap();
        ss_low();
        spi_xfer(8'h04, 8, rx);
        wait_clk(4);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("mr_busy", {31'd0, BUSY}, 32'd0);
        check("mr_addr", {28'd0, REG_ADDR}, 32'd0);
        check("mr_wdata", {24'd0, REG_WDATA}, 32'd0);
        check("mr_miso", {31'd0, MISO}, 32'd0);
        spi_xfer(8'h99, 8, rx);
        ss_high();
        wait_clk(6);
        check("mr_we_none", we_cnt - we_base, 32'd0);
        check("mr_err_none", err_cnt - err_base, 32'd0);
        snap();
        ss_low();
        spi_xfer(8'h09, 8, rx);
        spi_xfer(8'h99, 8, rx);
        ss_high();
        wait_clk(6);
        check("mr_we_cnt", we_cnt - we_base, 32'd1);
        check("mr_new_addr", {28'd0, log_addr[we_base]}, 32'd9);
        check("mr_new_data", {24'd0, log_data[we_base]}, 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
